// File: rtl/bcd_7seg_scan.sv
// Four-digit multiplexed seven-segment driver with a double-buffered digit capture,
// leading-zero blanking and registered pin outputs.
module bcd_7seg_scan #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int DIGIT_HZ    = 1000,
   parameter int ACTIVE_LOW  = 1,
   parameter int LZ_BLANK    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   input  logic [3:0] hundreds,
   input  logic [3:0] thousands,
   input  logic       load,
   input  logic       blank_all,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_done
);

   localparam int DIV_RAW = CLK_FREQ_HZ / DIGIT_HZ;
   localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
   localparam int PW      = $clog2(DIV);
   localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

   localparam logic [3:0] AN_OFF  = (ACTIVE_LOW != 0) ? 4'hF : 4'h0;
   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (ACTIVE_LOW != 0);

   logic [PW-1:0] prescaler;
   logic [1:0]    idx;
   logic [3:0]    pend [4];
   logic [3:0]    disp [4];
   logic          pend_valid;

   logic          tick;
   logic          frame_end;
   logic [3:0]    cur_digit;
   logic          bk1, bk2, bk3;
   logic [3:0]    an_en;
   logic [3:0]    an_hi;
   logic [6:0]    seg_hi;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   assign tick      = (prescaler == PMAX);
   assign frame_end = tick && (idx == 2'd3);

   // Blanking is judged on what is being displayed, never on the pending buffer.
   always_comb begin
      cur_digit = disp[idx];
      bk3       = (disp[3] == 4'd0);
      bk2       = bk3 && (disp[2] == 4'd0);
      bk1       = bk2 && (disp[1] == 4'd0);
      if (LZ_BLANK != 0) an_en = {~bk3, ~bk2, ~bk1, 1'b1};
      else               an_en = 4'hF;
      an_hi  = (4'b0001 << idx) & an_en & {4{~blank_all}};
      seg_hi = decode(cur_digit);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         idx       <= 2'd0;
      end else begin
         prescaler <= tick ? '0 : prescaler + PW'(1);
         if (tick) idx <= idx + 2'd1;
      end
   end

   // A load on the boundary cycle bypasses the pending buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            pend[i] <= 4'd0;
            disp[i] <= 4'd0;
         end
         pend_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (frame_end) begin
            pend_valid <= 1'b0;
            if (load) begin
               disp[0] <= ones;
               disp[1] <= tens;
               disp[2] <= hundreds;
               disp[3] <= thousands;
            end else if (pend_valid) begin
               for (int i = 0; i < 4; i++) disp[i] <= pend[i];
            end
         end else if (load) begin
            pend[0]    <= ones;
            pend[1]    <= tens;
            pend[2]    <= hundreds;
            pend[3]    <= thousands;
            pend_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= DP_OFF;
      end else begin
         an  <= (ACTIVE_LOW != 0) ? ~an_hi : an_hi;
         seg <= (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
         dp  <= DP_OFF;
      end
   end

endmodule
